range_counter_core: RTL and testbench

`range_counter` asserts a fixed-length activity window that begins when a free-running external counter reaches a programmable trigger value. It loads a trigger count, watches `counter`, and raises `active` for exactly `range_duration` enabled clock ticks. While the window is open it reports progress on `elapsed`. It sits beside video and scan timing counters, for example to mark sprite or paddle spans along a line.

---
 rtl/range_counter_core_pkg.sv | 8 +
 rtl/range_counter_core_timer.sv | 45 ++++
 rtl/range_counter_core.sv | 46 ++++
 tb/tb_range_counter_core.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/range_counter_core_pkg.sv
// Shared timing defaults for the range counter: counter/elapsed widths and window length.
package range_counter_core_pkg;

  localparam int counter_width_default  = 8;
  localparam int elapsed_width_default  = 4;
  localparam int range_duration_default = 6;

endpackage

// File: rtl/range_counter_core_timer.sv
// Window timer: holds the active flag and up-counts elapsed enabled ticks until the terminal count.
module range_counter_core_timer
  import range_counter_core_pkg::*;
#(
  parameter int elapsed_width  = elapsed_width_default,
  parameter int range_duration = range_duration_default
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     tick,
  input  logic                     start,
  output logic                     active,
  output logic [elapsed_width-1:0] elapsed
);

  localparam logic [elapsed_width-1:0] last_tick = elapsed_width'(range_duration - 1);

  logic terminal;
  assign terminal = (elapsed == last_tick);

  // clear (trigger reload) outranks the tick qualifier, so a load aborts even when stalled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active  <= 1'b0;
      elapsed <= '0;
    end else if (clear) begin
      active  <= 1'b0;
      elapsed <= '0;
    end else if (tick) begin
      if (!active) begin
        if (start) begin
          active  <= 1'b1;
          elapsed <= '0;
        end
      end else if (terminal) begin
        active  <= 1'b0;
        elapsed <= '0;
      end else begin
        elapsed <= elapsed + 1'b1;
      end
    end
  end

endmodule

// File: rtl/range_counter_core.sv
// Opens a fixed-length activity window when an external counter equals a loadable trigger value.
module range_counter_core
  import range_counter_core_pkg::*;
#(
  parameter int counter_width  = counter_width_default,
  parameter int elapsed_width  = elapsed_width_default,
  parameter int range_duration = range_duration_default
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [counter_width-1:0] on_count,
  input  logic [counter_width-1:0] counter,
  input  logic                     enable,
  output logic                     active,
  output logic [elapsed_width-1:0] elapsed
);

  logic [counter_width-1:0] trig_reg;
  logic                     match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_reg <= '0;
    end else if (load) begin
      trig_reg <= on_count;
    end
  end

  // compared against the old trigger; on a load edge the timer is cleared anyway
  assign match = (counter == trig_reg);

  range_counter_core_timer #(
    .elapsed_width  (elapsed_width),
    .range_duration (range_duration)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (load),
    .tick    (enable),
    .start   (match),
    .active  (active),
    .elapsed (elapsed)
  );

endmodule

// File: tb/tb_range_counter_core.sv
// Directed bench for range_counter_core with hand-computed window expectations.
module tb_range_counter_core;

  logic       clock;
  logic       reset;
  logic       load;
  logic [7:0] on_count;
  logic [7:0] counter;
  logic       enable;
  logic       active;
  logic [3:0] elapsed;

  int checks;
  int errors;
  int high_count;

  range_counter_core dut (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .on_count (on_count),
    .counter  (counter),
    .enable   (enable),
    .active   (active),
    .elapsed  (elapsed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then compare 1 time unit later.
  task automatic step(input string tag, input logic ld, input logic [7:0] oc,
                      input logic [7:0] cnt, input logic en,
                      input int exp_a, input int exp_e);
    load     = ld;
    on_count = oc;
    counter  = cnt;
    enable   = en;
    @(posedge clock);
    #1;
    $display("%s load=%0d on_count=%0d counter=%0d enable=%0d -> active=%0d elapsed=%0d",
             tag, ld, oc, cnt, en, active, elapsed);
    check_val({tag, "_active"}, int'(active), exp_a);
    check_val({tag, "_elapsed"}, int'(elapsed), exp_e);
    if (active) high_count++;
    load = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    high_count = 0;
    reset      = 1'b0;
    load       = 1'b0;
    on_count   = 8'd0;
    counter    = 8'd0;
    enable     = 1'b0;

    // reset held for 3 cycles
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_active", int'(active), 0);
    check_val("reset_elapsed", int'(elapsed), 0);
    reset = 1'b1;
    #1;
    check_val("release_active", int'(active), 0);
    check_val("release_elapsed", int'(elapsed), 0);

    // basic window at trigger 5
    step("load5", 1'b1, 8'd5, 8'd0, 1'b1, 0, 0);
    for (int c = 0; c <= 30; c++) begin
      if (c >= 5 && c <= 10) step("sweep5", 1'b0, 8'd0, 8'(c), 1'b1, 1, c - 5);
      else                   step("sweep5", 1'b0, 8'd0, 8'(c), 1'b1, 0, 0);
    end

    // reload to 20: 5 must no longer trigger
    step("load20", 1'b1, 8'd20, 8'd0, 1'b1, 0, 0);
    for (int c = 0; c <= 30; c++) begin
      if (c >= 20 && c <= 25) step("sweep20", 1'b0, 8'd0, 8'(c), 1'b1, 1, c - 20);
      else                    step("sweep20", 1'b0, 8'd0, 8'(c), 1'b1, 0, 0);
    end

    // load abort at elapsed 3; matching counter on the load edge must not start
    step("load8", 1'b1, 8'd8, 8'd0, 1'b1, 0, 0);
    step("abort_run", 1'b0, 8'd0, 8'd8, 1'b1, 1, 0);
    step("abort_run", 1'b0, 8'd0, 8'd9, 1'b1, 1, 1);
    step("abort_run", 1'b0, 8'd0, 8'd10, 1'b1, 1, 2);
    step("abort_run", 1'b0, 8'd0, 8'd11, 1'b1, 1, 3);
    step("abort_load", 1'b1, 8'd8, 8'd8, 1'b1, 0, 0);
    step("abort_after", 1'b0, 8'd0, 8'd9, 1'b1, 0, 0);
    step("abort_idle_dis", 1'b0, 8'd0, 8'd8, 1'b0, 0, 0);
    for (int k = 0; k <= 5; k++)
      step("fresh", 1'b0, 8'd0, 8'(8 + k), 1'b1, 1, k);
    // match on the ending edge must not restart
    step("end_match", 1'b0, 8'd0, 8'd8, 1'b1, 0, 0);
    step("no_restart", 1'b0, 8'd0, 8'd9, 1'b1, 0, 0);

    // enable stall of 4 cycles mid-window, with matches ignored while active
    high_count = 0;
    step("stall_run", 1'b0, 8'd0, 8'd8, 1'b1, 1, 0);
    step("stall_run", 1'b0, 8'd0, 8'd9, 1'b1, 1, 1);
    step("stall_run", 1'b0, 8'd0, 8'd10, 1'b1, 1, 2);
    for (int k = 0; k < 4; k++)
      step("stall_hold", 1'b0, 8'd0, 8'd8, 1'b0, 1, 2);
    step("stall_run", 1'b0, 8'd0, 8'd8, 1'b1, 1, 3);
    step("stall_run", 1'b0, 8'd0, 8'd12, 1'b1, 1, 4);
    step("stall_run", 1'b0, 8'd0, 8'd13, 1'b1, 1, 5);
    step("stall_end", 1'b0, 8'd0, 8'd14, 1'b1, 0, 0);
    check_val("stall_high_cycles", high_count, 10);

    // asynchronous reset mid-window at elapsed 2
    step("rst_run", 1'b0, 8'd0, 8'd8, 1'b1, 1, 0);
    step("rst_run", 1'b0, 8'd0, 8'd9, 1'b1, 1, 1);
    step("rst_run", 1'b0, 8'd0, 8'd10, 1'b1, 1, 2);
    #1;
    reset = 1'b0;
    #1;
    check_val("async_rst_active", int'(active), 0);
    check_val("async_rst_elapsed", int'(elapsed), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    for (int k = 0; k <= 5; k++)
      step("post_rst", 1'b0, 8'd0, 8'(k), 1'b1, 1, k);
    step("post_rst_end", 1'b0, 8'd0, 8'd6, 1'b1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=%0d", checks, 0);
    $fatal(1, "simulation timeout");
  end

endmodule
